hyper_evt_router: RTL and testbench
===================================

# hyper_evt_router

Downstream stage of the HyperBus uDMA macro. Captures the 4-line event pulse vector the macro emits (RX channel, TX channel, read EOT, write EOT), serialises simultaneous pulses into a queue of event IDs, and presents them one at a time to the SoC event unit over a valid/ready handshake. Also flags lost events and reports queue occupancy.

## Interface
- EVT_W, 4, number of event lines (bit i of `evt_i` maps to ID `cfg_evt_base_i + i`)
- DEPTH, 8, ID queue depth (power of two, ≥2)
- ID_W, 8, event ID width
- sys_clk_i  in  1  single clock for all logic
- rst_i  in  1  reset, synchronous, active-high
- evt_i  in  EVT_W  event pulses (udma_evt_t), one cycle high per event
- cfg_en_i  in  1  capture enable; when low, new pulses are ignored (queue still drains)
- cfg_evt_base_i  in  ID_W  base event ID, sampled at push time
- evt_valid_o  out  1  queue head valid
- evt_id_o  out  ID_W  queue head ID
- evt_ready_i  in  1  consumer accepts head
- ovf_o  out  1  sticky lost-event flag
- ovf_clr_i  in  1  clears `ovf_o`
- pending_o  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- `pend_q[EVT_W]`: per-line pending mask. Each cycle: `pend_d = (pend_q & ~grant) | (cfg_en_i ? evt_i : 0)`.
- Arbiter: fixed priority, lowest index wins. At most one grant per cycle. Grant only if push is possible: queue not full, or full with a pop in the same cycle.
- Push writes `cfg_evt_base_i + idx` (ID_W wrap-around add, carry dropped) into the queue.
- Lost event: `evt_i[i] & cfg_en_i & pend_q[i] & ~grant[i]` sets `ovf_o`. Same-cycle set and `ovf_clr_i`: set wins.
- A pulse on a line granted in the same cycle re-arms `pend` (not lost).
- Pop: `evt_valid_o & evt_ready_i`. `evt_id_o` is stable while `evt_valid_o & ~evt_ready_i`.
- `pending_o` counts +1 on push, −1 on pop, unchanged on both.
- Reset: `pend_q=0`, queue empty, `evt_valid_o=0`, `evt_id_o=0`, `ovf_o=0`, `pending_o=0`. Reset mid-operation discards all pending and queued events.

## Timing
- Pulse in cycle N → `pend_q` set in N+1 → granted in N+1 if it has priority and there is room → `evt_valid_o` high in N+2. Minimum latency is 2 cycles.
- Simultaneous pulses on k lines: their IDs appear on k consecutive cycles in index order, provided `evt_ready_i` stays high.
- Full queue with `evt_ready_i` low: no grants are issued and pending bits hold. Any repeat pulse on a pending line sets `ovf_o`.
- Full queue and pop in the same cycle: push is accepted and `pending_o` stays at DEPTH.
- Throughput: 1 event/cycle sustained.

## Configuration
- `HYPER_EVT_CNT_EN` defined: adds output `evt_cnt_o` of width EVT_W*16.
  - Per-line 16-bit saturating counters.
  - Increment on each pulse accepted into `pend` (lost pulses are not counted).
  - Cleared by `ovf_clr_i`, which takes priority over increment.
  - Reset value 0.
- `HYPER_EVT_CNT_EN` undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Existing shared package `udma_pkg` holds:
  - `udma_evt_t` (event vector type);
  - constant `HYPER_EVT_NB = 4`;
  - localparam-style index constants `HYPER_EVT_RX=0`, `TX=1`, `RD_EOT=2`, `WR_EOT=3`.
- One sub-module: `hyper_evt_fifo`, a synchronous DEPTH×ID_W FIFO with push/pop/full/empty/count. It supports push-when-full-with-pop and is first-word-fall-through.
- The top level holds the pending mask, arbiter, overflow logic and optional counters.

## Test plan
- Reset, base=0x20, single pulse on line 2 in cycle 5, ready=1 → `evt_valid_o` in cycle 7 with ID 0x22 for one cycle; `pending_o` 0→1→0.
- `evt_i=4'b1111` in one cycle, ready=1 → IDs 0x20, 0x21, 0x22, 0x23 on four consecutive cycles; `ovf_o=0`.
- ready=0, line 0 pulsed 9 times with DEPTH=8 → 8 entries queued, `pending_o=8`, then the ninth pulse sits pending. A tenth pulse sets `ovf_o`. Then ready=1 → 9 IDs drain, `ovf_clr_i` clears the flag.
- Queue full, ready=1, and a line pending → push and pop occur in the same cycle, `pending_o` stays at 8, and no event is lost.
- base=0xFE, pulse on line 3 → ID 0x01 (wrap-around).
- `rst_i` asserted with 5 entries queued and 2 lines pending → the next cycle has `evt_valid_o=0`, `pending_o=0`, `ovf_o=0`; with `HYPER_EVT_CNT_EN` defined, all counters are 0.

Source files
------------

// File: rtl/udma_pkg.sv
// Shared uDMA package: event vector type and HyperBus event line indices.
package udma_pkg;

    localparam int HYPER_EVT_NB = 4;

    // One bit per event line, one-cycle pulses from the HyperBus macro.
    typedef logic [HYPER_EVT_NB-1:0] udma_evt_t;

    localparam int HYPER_EVT_RX     = 0;
    localparam int HYPER_EVT_TX     = 1;
    localparam int HYPER_EVT_RD_EOT = 2;
    localparam int HYPER_EVT_WR_EOT = 3;

    localparam int HYPER_EVT_ID_W   = 8;
    localparam int HYPER_EVT_DEPTH  = 8;

endpackage

// File: rtl/hyper_evt_fifo.sv
// First-word-fall-through ID queue for hyper_evt_router.
// A push while full is accepted only when a pop happens in the same cycle.
// The read data is forced to zero while empty so the head ID is deterministic.
module hyper_evt_fifo
    import udma_pkg::*;
#(
    parameter int DEPTH = HYPER_EVT_DEPTH,
    parameter int W     = HYPER_EVT_ID_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          full_s;
    logic          empty_s;

    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

    // Head word, zero while nothing is queued.
    always_comb begin
        rdata = {W{1'b0}};
        if (!empty_s) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = {W{1'b0}};
        end
    end

    // Storage write; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hyper_evt_router.sv
// HyperBus event router: latches event pulses into a pending mask, serialises
// them lowest-line-first into an ID queue and hands IDs to the event unit.
// Optional feature macro: HYPER_EVT_CNT_EN adds per-line 16-bit saturating
// pulse counters on evt_cnt_o.
// evt_i is bit-compatible with udma_pkg::udma_evt_t when EVT_W == HYPER_EVT_NB.
module hyper_evt_router
    import udma_pkg::*;
#(
    parameter int EVT_W = HYPER_EVT_NB,
    parameter int DEPTH = HYPER_EVT_DEPTH,
    parameter int ID_W  = HYPER_EVT_ID_W
) (
    input  logic                       sys_clk_i,
    input  logic                       rst_i,
    input  logic [EVT_W-1:0]           evt_i,
    input  logic                       cfg_en_i,
    input  logic [ID_W-1:0]            cfg_evt_base_i,
    output logic                       evt_valid_o,
    output logic [ID_W-1:0]            evt_id_o,
    input  logic                       evt_ready_i,
    output logic                       ovf_o,
    input  logic                       ovf_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] pending_o
`ifdef HYPER_EVT_CNT_EN
    ,
    output logic [EVT_W*16-1:0]        evt_cnt_o
`endif
);

    logic [EVT_W-1:0] pend_r;
    logic [EVT_W-1:0] arm_s;
    logic [EVT_W-1:0] grant_s;
    logic [EVT_W-1:0] lost_s;
    logic [ID_W-1:0]  idx_s;
    logic [ID_W-1:0]  push_id_s;
    logic             found_s;
    logic             can_push_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             ovf_r;

    assign arm_s       = cfg_en_i ? evt_i : {EVT_W{1'b0}};
    assign pop_s       = ~empty_s & evt_ready_i;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign can_push_s  = ~full_s | pop_s;
    assign push_s      = found_s;
    assign push_id_s   = cfg_evt_base_i + idx_s;
    // A repeat pulse on a line that is still waiting cannot be recorded.
    assign lost_s      = arm_s & pend_r & ~grant_s;
    assign evt_valid_o = ~empty_s;
    assign ovf_o       = ovf_r;

    // Fixed-priority arbiter: lowest pending line wins, only when a push fits.
    always_comb begin
        grant_s = {EVT_W{1'b0}};
        idx_s   = {ID_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < EVT_W; i++) begin
            if (pend_r[i] && !found_s && can_push_s) begin
                grant_s[i] = 1'b1;
                idx_s      = ID_W'(i);
                found_s    = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Pending mask: granted lines clear, new pulses (even on a granted line) arm.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            pend_r <= {EVT_W{1'b0}};
        end else begin
            pend_r <= (pend_r & ~grant_s) | arm_s;
        end
    end

    // Sticky lost-event flag; a new loss beats a same-cycle clear.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (|lost_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    hyper_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .wdata (push_id_s),
        .pop   (pop_s),
        .rdata (evt_id_o),
        .full  (full_s),
        .empty (empty_s),
        .count (pending_o)
    );

`ifdef HYPER_EVT_CNT_EN
    logic [15:0] cnt_r [EVT_W];

    // Per-line saturating pulse counters; clear wins over increment.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < EVT_W; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < EVT_W; i++) begin
                if (ovf_clr_i) begin
                    cnt_r[i] <= 16'd0;
                end else if (arm_s[i] && !lost_s[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < EVT_W; g++) begin : g_cnt_out
        assign evt_cnt_o[g*16 +: 16] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_hyper_evt_router.sv
// Self-checking bench for hyper_evt_router (build with or without
// HYPER_EVT_CNT_EN). A queue-based model tracks the expected outputs.
module tb_hyper_evt_router;

    localparam int EVT_W = 4;
    localparam int DEPTH = 8;
    localparam int ID_W  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  evt = 4'd0;
    logic        en = 1'b1;
    logic [7:0]  base = 8'h20;
    logic        ready = 1'b1;
    logic        clr = 1'b0;
    logic        evt_valid_o;
    logic [7:0]  evt_id_o;
    logic        ovf_o;
    logic [3:0]  pending_o;
`ifdef HYPER_EVT_CNT_EN
    logic [63:0] evt_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   mq[$];
    bit   mpend[4];
    bit   movf;
    int   mcnt[4];
    logic       exp_valid;
    logic [7:0] exp_id;
    logic [3:0] exp_pend;
    logic [63:0] exp_cnt;

    hyper_evt_router #(
        .EVT_W (EVT_W),
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) dut (
        .sys_clk_i      (clk),
        .rst_i          (rst),
        .evt_i          (evt),
        .cfg_en_i       (en),
        .cfg_evt_base_i (base),
        .evt_valid_o    (evt_valid_o),
        .evt_id_o       (evt_id_o),
        .evt_ready_i    (ready),
        .ovf_o          (ovf_o),
        .ovf_clr_i      (clr),
        .pending_o      (pending_o)
`ifdef HYPER_EVT_CNT_EN
        ,
        .evt_cnt_o      (evt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one clock edge of behaviour to the model using the current inputs.
    task automatic model_step();
        bit pop;
        bit room;
        int g;
        bit lost[4];
        bit anylost;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) begin
                mpend[i] = 1'b0;
                mcnt[i] = 0;
            end
            movf = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && ready;
            room = (mq.size() < DEPTH) || pop;
            g = -1;
            if (room) begin
                for (int i = 3; i >= 0; i--) if (mpend[i]) g = i;
            end
            anylost = 1'b0;
            for (int i = 0; i < 4; i++) begin
                lost[i] = en && evt[i] && mpend[i] && (g != i);
                anylost |= lost[i];
            end
            if (pop) void'(mq.pop_front());
            if (g >= 0) mq.push_back((int'(base) + g) % 256);
            for (int i = 0; i < 4; i++) begin
                if (clr) mcnt[i] = 0;
                else if (en && evt[i] && !lost[i] && mcnt[i] < 65535) mcnt[i]++;
                mpend[i] = (mpend[i] && (g != i)) || (en && evt[i]);
            end
            if (anylost) movf = 1'b1;
            else if (clr) movf = 1'b0;
        end
        exp_valid = (mq.size() > 0);
        exp_id    = exp_valid ? 8'(mq[0]) : 8'h00;
        exp_pend  = 4'(mq.size());
        for (int i = 0; i < 4; i++) exp_cnt[i*16 +: 16] = 16'(mcnt[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (evt_valid_o !== 1'b0 || evt_id_o !== 8'h00 || ovf_o !== 1'b0 || pending_o !== 4'd0) begin
            errors++;
            $display("FAIL reset: got v=%b id=%h ovf=%b pend=%0d, need 0/00/0/0",
                     evt_valid_o, evt_id_o, ovf_o, pending_o);
        end
    endtask

    task automatic test_single_pulse();
        base = 8'h20; ready = 1'b1; en = 1'b1;
        evt = 4'b0100;
        tick();
        evt = 4'b0000;
        checks++;
        if (evt_valid_o !== 1'b0 || pending_o !== 4'd0) begin
            errors++;
            $display("FAIL single_lat1: got v=%b pend=%0d, need 0/0", evt_valid_o, pending_o);
        end
        tick();
        checks++;
        if (evt_valid_o !== 1'b1 || evt_id_o !== 8'h22 || pending_o !== 4'd1) begin
            errors++;
            $display("FAIL single_lat2: got v=%b id=%h pend=%0d, need 1/22/1",
                     evt_valid_o, evt_id_o, pending_o);
        end
        tick();
        checks++;
        if (evt_valid_o !== 1'b0 || pending_o !== 4'd0) begin
            errors++;
            $display("FAIL single_pop: got v=%b pend=%0d, need 0/0", evt_valid_o, pending_o);
        end
    endtask

    task automatic test_all_lines();
        logic [7:0] want;
        base = 8'h20; ready = 1'b1;
        evt = 4'b1111;
        tick();
        evt = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            want = 8'h20 + 8'(k);
            checks++;
            if (evt_valid_o !== 1'b1 || evt_id_o !== want || ovf_o !== 1'b0) begin
                errors++;
                $display("FAIL all_lines[%0d]: got v=%b id=%h ovf=%b, need 1/%h/0",
                         k, evt_valid_o, evt_id_o, ovf_o, want);
            end
        end
        tick();
        checks++;
        if (evt_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL all_lines_end: got v=%b, need 0", evt_valid_o);
        end
    endtask

    task automatic test_full_queue();
        int pops;
        base = 8'h20; ready = 1'b0; en = 1'b1;
        evt = 4'b0001;
        repeat (9) tick();
        evt = 4'b0000;
        tick();
        checks++;
        if (pending_o !== 4'd8 || evt_valid_o !== 1'b1 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL full_fill: got pend=%0d v=%b ovf=%b, need 8/1/0", pending_o, evt_valid_o, ovf_o);
        end
        evt = 4'b0001;
        tick();
        evt = 4'b0000;
        checks++;
        if (ovf_o !== 1'b1 || pending_o !== 4'd8) begin
            errors++;
            $display("FAIL full_lost: got ovf=%b pend=%0d, need 1/8", ovf_o, pending_o);
        end
        ready = 1'b1;
        pops = 0;
        if (evt_valid_o) pops++;
        tick();
        checks++;
        if (pending_o !== 4'd8 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got pend=%0d ovf=%b, need 8/1", pending_o, ovf_o);
        end
        for (int c = 0; c < 20 && evt_valid_o; c++) begin
            checks++;
            if (evt_id_o !== 8'h20) begin
                errors++;
                $display("FAIL full_drain_id: got %h, need 20", evt_id_o);
            end
            pops++;
            tick();
        end
        checks++;
        if (pops != 9 || pending_o !== 4'd0) begin
            errors++;
            $display("FAIL full_drain_cnt: got pops=%0d pend=%0d, need 9/0", pops, pending_o);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b, need 0", ovf_o);
        end
    endtask

    task automatic test_wrap();
        base = 8'hFE; ready = 1'b1;
        evt = 4'b1000;
        tick();
        evt = 4'b0000;
        tick();
        checks++;
        if (evt_valid_o !== 1'b1 || evt_id_o !== 8'h01) begin
            errors++;
            $display("FAIL wrap: got v=%b id=%h, need 1/01", evt_valid_o, evt_id_o);
        end
        tick();
    endtask

`ifdef HYPER_EVT_CNT_EN
    task automatic test_counters();
        clr = 1'b1;
        tick();
        clr = 1'b0; ready = 1'b1; en = 1'b1;
        repeat (3) begin
            evt = 4'b0010; tick(); evt = 4'b0000; tick();
        end
        evt = 4'b1000; tick();
        en = 1'b0; evt = 4'b0100; tick();
        en = 1'b1; evt = 4'b0000;
        repeat (4) tick();
        checks++;
        if (evt_cnt_o !== 64'h0001_0000_0003_0000) begin
            errors++;
            $display("FAIL counters: got %h, need 0001000000030000", evt_cnt_o);
        end
        clr = 1'b1; evt = 4'b0001;
        tick();
        clr = 1'b0; evt = 4'b0000;
        checks++;
        if (evt_cnt_o !== 64'd0) begin
            errors++;
            $display("FAIL cnt_clear_prio: got %h, need 0", evt_cnt_o);
        end
        repeat (3) tick();
    endtask
`endif

    task automatic test_reset_mid();
        base = 8'h40; ready = 1'b0; en = 1'b1;
        evt = 4'b0001;
        repeat (5) tick();
        evt = 4'b0110;
        tick();
        evt = 4'b0000;
        checks++;
        if (pending_o !== 4'd5) begin
            errors++;
            $display("FAIL mid_fill: got pend=%0d, need 5", pending_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (evt_valid_o !== 1'b0 || pending_o !== 4'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b pend=%0d ovf=%b, need 0/0/0", evt_valid_o, pending_o, ovf_o);
        end
`ifdef HYPER_EVT_CNT_EN
        checks++;
        if (evt_cnt_o !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt: got %h, need 0", evt_cnt_o);
        end
`endif
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if (evt_valid_o !== 1'b0 || pending_o !== 4'd0) begin
            errors++;
            $display("FAIL mid_discard: got v=%b pend=%0d, need 0/0", evt_valid_o, pending_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            evt   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            ready = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            en    = ($urandom_range(0, 7) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) base = 8'($urandom);
            tick();
            checks++;
            if ({evt_valid_o, evt_id_o, pending_o, ovf_o} !== {exp_valid, exp_id, exp_pend, movf}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b id=%h pend=%0d ovf=%b, need v=%b id=%h pend=%0d ovf=%b",
                         c, evt_valid_o, evt_id_o, pending_o, ovf_o, exp_valid, exp_id, exp_pend, movf);
            end
`ifdef HYPER_EVT_CNT_EN
            checks++;
            if (evt_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL random_cnt[%0d]: got %h, need %h", c, evt_cnt_o, exp_cnt);
            end
`endif
        end
        evt = 4'd0; rst = 1'b0; clr = 1'b0; en = 1'b1; ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_all_lines();
        test_full_queue();
        test_wrap();
`ifdef HYPER_EVT_CNT_EN
        test_counters();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
